// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Stalls the core from issue until the result is in HI/LO, and owns HI and LO.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mdc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] MDC_MULT  = 3'd1;
    localparam logic [2:0] MDC_MULTU = 3'd2;
    localparam logic [2:0] MDC_DIV   = 3'd3;
    localparam logic [2:0] MDC_DIVU  = 3'd4;
    localparam logic [2:0] MDC_MTHI  = 3'd5;
    localparam logic [2:0] MDC_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;      // |multiplicand| or |divisor|
    logic [31:0] raw_a;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    // Decode of the incoming opcode while idle
    logic        start;
    logic        start_sgn;
    logic        start_div;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        start     = 1'b0;
        start_sgn = 1'b0;
        start_div = 1'b0;
        if (mdc == MDC_MULT || mdc == MDC_MULTU || mdc == MDC_DIV || mdc == MDC_DIVU)
            start = (state == IDLE);
        if (mdc == MDC_MULT || mdc == MDC_DIV)
            start_sgn = 1'b1;
        if (mdc == MDC_DIV || mdc == MDC_DIVU)
            start_div = 1'b1;
        abs_a = (start_sgn && a[31]) ? -a : a;
        abs_b = (start_sgn && b[31]) ? -b : b;
    end

    // One iteration of each algorithm
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_cand;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        div_cand = acc[63:31];
        div_diff = div_cand - {1'b0, opnd};
        // A borrow out of bit 32 means the trial subtraction went negative: restore.
        if (div_diff[32])
            div_next = {div_cand[31:0], acc[30:0], 1'b0};
        else
            div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end

    // Final sign correction applied in FIX; unsigned ops latch clear sign flags
    logic [63:0] fix_result;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        quo = acc[31:0];
        rem = acc[63:32];
        if (!op_div)
            fix_result = neg_q ? -acc : acc;
        else if (div_zero)
            fix_result = {raw_a, 32'hFFFF_FFFF};
        else
            fix_result = {neg_r ? -rem : rem, neg_q ? -quo : quo};
    end

    assign stall = start || (state == RUN) || (state == FIX);

    // Control state and the architecturally visible HI/LO
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= 5'd0;
                        busy  <= 1'b1;
                    end else if (mdc == MDC_MTHI) begin
                        hi <= a;
                    end else if (mdc == MDC_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_result[63:32];
                    lo    <= fix_result[31:0];
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the datapath is left unreset; it is always loaded at issue before it is read.
    always_ff @(posedge clk) begin
        if (start) begin
            acc      <= {32'd0, start_div ? abs_a : abs_b};
            opnd     <= start_div ? abs_b : abs_a;
            raw_a    <= a;
            op_div   <= start_div;
            neg_q    <= start_sgn && (a[31] ^ b[31]);
            neg_r    <= start_sgn && start_div && a[31];
            div_zero <= (b == 32'd0);
        end else if (state == RUN) begin
            acc <= op_div ? div_next : mul_next;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO queued at issue, checked on done.
module tb_muldiv_seq;

    localparam logic [2:0] MDC_NONE  = 3'd0;
    localparam logic [2:0] MDC_MULT  = 3'd1;
    localparam logic [2:0] MDC_MULTU = 3'd2;
    localparam logic [2:0] MDC_DIV   = 3'd3;
    localparam logic [2:0] MDC_DIVU  = 3'd4;
    localparam logic [2:0] MDC_MTHI  = 3'd5;
    localparam logic [2:0] MDC_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  mdc = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .mdc   (mdc),
        .a     (a),
        .b     (b),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    // Reference result {hi, lo} computed with native 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] av,
                                          input logic [31:0] bv);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa  = $signed({{32{av[31]}}, av});
        sbv = $signed({{32{bv[31]}}, bv});
        case (op)
            MDC_MULT:  return sa * sbv;
            MDC_MULTU: return {32'd0, av} * {32'd0, bv};
            MDC_DIV: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(av) / $signed(bv);
                r = $signed(av) % $signed(bv);
                return {r, q};
            end
            MDC_DIVU: begin
                if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
                return {av % bv, av / bv};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Called just after a falling edge; returns just after the falling edge of the
    // first IDLE cycle with mdc cleared, so a following op issues there.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_hl, input string name);
        exp_t e;
        int   stall_n = 0;
        int   done_n  = 0;
        bit   hold_ok = 1'b1;
        bit   accepted = 1'b0;
        mdc = op;
        a   = av;
        b   = bv;
        sb.push_back('{exp_hl[63:32], exp_hl[31:0], name});
        for (int i = 0; i < 60 && done_n == 0; i++) begin
            #1;
            if (stall) stall_n++;
            if (i == 1) accepted = busy;
            if (!done && (hi !== model_hi || lo !== model_lo)) hold_ok = 1'b0;
            if (done) begin
                done_n++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (hi !== e.hi) begin
                        errors++;
                        $display("FAIL %s hi: got %08h expected %08h", e.name, hi, e.hi);
                    end
                    checks++;
                    if (lo !== e.lo) begin
                        errors++;
                        $display("FAIL %s lo: got %08h expected %08h", e.name, lo, e.lo);
                    end
                    model_hi = e.hi;
                    model_lo = e.lo;
                end
            end
            @(negedge clk);
            // Operands change after the accepting edge and must not matter
            if (i == 0) begin
                a = $urandom;
                b = $urandom;
            end
        end
        mdc = MDC_NONE;
        checks++;
        if (done_n == 0) begin
            errors++;
            $display("FAIL %s done: no done pulse within 60 cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL %s accept: busy low the cycle after issue", name);
        end
        checks++;
        if (stall_n != 34) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected 34", name, stall_n);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL %s hold: hi/lo changed before done (expected %08h/%08h)",
                     name, model_hi, model_lo);
        end
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b expected 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mdc = MDC_NONE;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall, busy, done} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset: stall=%b busy=%b done=%b hi=%08h lo=%08h expected 0/0/0/0/0",
                     stall, busy, done, hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multiply();
        run_op(MDC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(MDC_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5");
        run_op(MDC_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minxmin");
    endtask

    task automatic test_divide();
        run_op(MDC_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2");
        run_op(MDC_DIVU, 32'd7, 32'h8000_0000, 64'h0000_0007_0000_0000, "divu_7bybig");
        run_op(MDC_DIVU, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, "divu_by_zero");
        run_op(MDC_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, "div_neg_by_zero");
        run_op(MDC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_overflow");
    endtask

    task automatic test_mthi_mtlo();
        mdc = MDC_MTHI;
        a   = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        checks++;
        if (hi !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mthi_value: got %08h expected a5a5a5a5", hi);
        end
        mdc = MDC_MTLO;
        a   = 32'h5A5A_5A5A;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        mdc = MDC_NONE;
        checks++;
        if (lo !== 32'h5A5A_5A5A || hi !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mtlo_value: got %08h/%08h expected a5a5a5a5/5a5a5a5a", hi, lo);
        end
        model_hi = 32'hA5A5_A5A5;
        model_lo = 32'h5A5A_5A5A;
    endtask

    task automatic test_back_to_back();
        // run_op holds mdc through DONE, and the multu issues in the first IDLE cycle
        run_op(MDC_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "b2b_div");
        run_op(MDC_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A, "b2b_multu");
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  op;
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'hFFFF);
            if (i[0]) rb = $urandom | 32'd1;
            op = 3'(i + 1);
            run_op(op, ra, rb, model(op, ra, rb), "random");
        end
    endtask

    task automatic test_abort();
        int done_seen = 0;
        mdc = MDC_MULT;
        a   = 32'd5;
        b   = 32'd7;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        mdc = MDC_NONE;
        @(negedge clk);
        #1;
        checks++;
        if ({stall, busy, done} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort: stall=%b busy=%b done=%b hi=%08h lo=%08h expected 0/0/0/0/0",
                     stall, busy, done, hi, lo);
        end
        rst = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d busy=%b expected 0/0", done_seen, busy);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_mthi_mtlo();
        test_back_to_back();
        test_random();
        // Make HI/LO non-zero before aborting so the reset clear is observable
        run_op(MDC_MULTU, 32'd3, 32'd3, 64'd9, "pre_abort");
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
